// File: rtl/uart_cmd_controller.sv
// SUMP-style command parser: turns UART receive bytes into capture-core
// configuration registers and one-cycle control strobes.
module uart_cmd_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned DIV_W          = 24
) (
  input  logic             input_clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_rdy,
  output logic [31:0]      trig_mask,
  output logic [31:0]      trig_value,
  output logic [DIV_W-1:0] divider,
  output logic [15:0]      read_count,
  output logic [15:0]      delay_count,
  output logic [7:0]       flags,
  output logic             arm_pulse,
  output logic             sw_reset_pulse,
  output logic             id_req_pulse,
  output logic             cfg_update,
  output logic             cmd_error
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state_q, state_d;
  logic             rdy_meta, rdy_sync, rdy_prev;
  logic             byte_stb;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       opcode_q, opcode_d;
  logic [31:0]      shift_q, shift_d;
  logic [31:0]      tm_q, tm_d, tv_q, tv_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      rc_q, rc_d, dc_q, dc_d;
  logic [7:0]       fl_q, fl_d;
  logic             arm_q, arm_d, swr_q, swr_d, id_q, id_d, cfg_q, cfg_d, err_q, err_d;

  assign byte_stb = rdy_sync & ~rdy_prev;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    opcode_d = opcode_q;
    shift_d  = shift_q;
    tm_d     = tm_q;
    tv_d     = tv_q;
    div_d    = div_q;
    rc_d     = rc_q;
    dc_d     = dc_q;
    fl_d     = fl_q;
    arm_d    = 1'b0;
    swr_d    = 1'b0;
    id_d     = 1'b0;
    cfg_d    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (byte_stb) begin
          case (rx_data)
            8'h00: begin
              swr_d = 1'b1;
              tm_d  = '0;
              tv_d  = '0;
              div_d = '0;
              rc_d  = '0;
              dc_d  = '0;
              fl_d  = '0;
            end
            8'h01: arm_d = 1'b1;
            8'h02: id_d  = 1'b1;
            8'h11, 8'h13: ;
            8'hC0, 8'hC1, 8'h80, 8'h81, 8'h82: begin
              opcode_d = rx_data;
              idx_d    = '0;
              shift_d  = '0;
              state_d  = COLLECT;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      COLLECT: begin
        if (byte_stb) begin
          // Shift right so the first byte ends up in bits [7:0] after four bytes.
          shift_d = {rx_data, shift_q[31:8]};
          idx_d   = idx_q + 2'd1;
          cnt_d   = '0;
          if (idx_q == 2'd3) begin
            cfg_d   = 1'b1;
            state_d = IDLE;
            case (opcode_q)
              8'hC0: tm_d = shift_d;
              8'hC1: tv_d = shift_d;
              8'h80: div_d = shift_d[DIV_W-1:0];
              8'h81: begin
                rc_d = shift_d[15:0];
                dc_d = shift_d[31:16];
              end
              default: fl_d = shift_d[7:0];
            endcase
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          shift_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge input_clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rdy_meta <= 1'b0;
      rdy_sync <= 1'b0;
      rdy_prev <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      opcode_q <= '0;
      shift_q  <= '0;
      tm_q     <= '0;
      tv_q     <= '0;
      div_q    <= '0;
      rc_q     <= '0;
      dc_q     <= '0;
      fl_q     <= '0;
      arm_q    <= 1'b0;
      swr_q    <= 1'b0;
      id_q     <= 1'b0;
      cfg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_meta <= rx_data_rdy;
      rdy_sync <= rdy_meta;
      rdy_prev <= rdy_sync;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      opcode_q <= opcode_d;
      shift_q  <= shift_d;
      tm_q     <= tm_d;
      tv_q     <= tv_d;
      div_q    <= div_d;
      rc_q     <= rc_d;
      dc_q     <= dc_d;
      fl_q     <= fl_d;
      arm_q    <= arm_d;
      swr_q    <= swr_d;
      id_q     <= id_d;
      cfg_q    <= cfg_d;
      err_q    <= err_d;
    end
  end

  assign trig_mask      = tm_q;
  assign trig_value     = tv_q;
  assign divider        = div_q;
  assign read_count     = rc_q;
  assign delay_count    = dc_q;
  assign flags          = fl_q;
  assign arm_pulse      = arm_q;
  assign sw_reset_pulse = swr_q;
  assign id_req_pulse   = id_q;
  assign cfg_update     = cfg_q;
  assign cmd_error      = err_q;

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Scoreboard bench for uart_cmd_controller: stimulus queues expected strobe
// events with register snapshots; a negedge monitor pops and compares them.
module tb_uart_cmd_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_data_rdy;
  logic [31:0] trig_mask, trig_value;
  logic [23:0] divider;
  logic [15:0] read_count, delay_count;
  logic [7:0]  flags;
  logic        arm_pulse, sw_reset_pulse, id_req_pulse, cfg_update, cmd_error;

  uart_cmd_controller #(.TIMEOUT_CYCLES(64), .DIV_W(24)) dut (
    .input_clk(clk), .reset(reset), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
    .trig_mask(trig_mask), .trig_value(trig_value), .divider(divider),
    .read_count(read_count), .delay_count(delay_count), .flags(flags),
    .arm_pulse(arm_pulse), .sw_reset_pulse(sw_reset_pulse), .id_req_pulse(id_req_pulse),
    .cfg_update(cfg_update), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  p;   // {arm, sw_reset, id_req, cfg_update, cmd_error}
    logic [31:0] tm;
    logic [31:0] tv;
    logic [23:0] dv;
    logic [15:0] rc;
    logic [15:0] dc;
    logic [7:0]  fl;
  } ev_t;

  localparam logic [4:0] P_ARM = 5'b10000, P_SWR = 5'b01000, P_ID = 5'b00100,
                         P_CFG = 5'b00010, P_ERR = 5'b00001;

  ev_t  exp_q[$];
  ev_t  model;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_err_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t observe();
    ev_t e;
    e.p  = {arm_pulse, sw_reset_pulse, id_req_pulse, cfg_update, cmd_error};
    e.tm = trig_mask;  e.tv = trig_value; e.dv = divider;
    e.rc = read_count; e.dc = delay_count; e.fl = flags;
    return e;
  endfunction

  // Monitor: any strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    ev_t a, e;
    a = observe();
    if (a.p != 5'b0) begin
      if (a.p[0]) last_err_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got pulses=%b tm=%h tv=%h dv=%h rc=%h dc=%h fl=%h, required none",
                 a.p, a.tm, a.tv, a.dv, a.rc, a.dc, a.fl);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL event: got pulses=%b tm=%h tv=%h dv=%h rc=%h dc=%h fl=%h, required pulses=%b tm=%h tv=%h dv=%h rc=%h dc=%h fl=%h",
                   a.p, a.tm, a.tv, a.dv, a.rc, a.dc, a.fl, e.p, e.tm, e.tv, e.dv, e.rc, e.dc, e.fl);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic push(input logic [4:0] p);
    ev_t e;
    e = model;
    e.p = p;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data = b;
    rx_data_rdy = 1'b1;
    repeat (hold) @(negedge clk);
    rx_data_rdy = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send5(input logic [7:0] op, input logic [31:0] d);
    logic [31:0] v;
    v = d;
    send_byte(op, 4);
    for (int unsigned k = 0; k < 4; k++) send_byte(v[8*k +: 8], 4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int c;
    reset = 1'b0;
    rx_data = '0;
    rx_data_rdy = 1'b0;
    model = '0;
    do_reset();
    check("reset_trig_mask", trig_mask, 32'h0);
    check("reset_trig_value", trig_value, 32'h0);
    check("reset_divider", {8'h0, divider}, 32'h0);
    check("reset_counts", {read_count, delay_count}, 32'h0);
    check("reset_flags", {24'h0, flags}, 32'h0);
    check("reset_pulses", {27'h0, arm_pulse, sw_reset_pulse, id_req_pulse, cfg_update, cmd_error}, 32'h0);

    // Arm: strobe visible exactly on the third negedge after rx_data_rdy rises.
    push(P_ARM);
    @(negedge clk);
    c = cyc;
    rx_data = 8'h01;
    rx_data_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk); check("arm_early", {31'h0, arm_pulse}, 32'h0);
    @(negedge clk); check("arm_on_time", {31'h0, arm_pulse}, 32'h1);
    @(negedge clk); check("arm_one_cycle", {31'h0, arm_pulse}, 32'h0);
    rx_data_rdy = 1'b0;
    repeat (4) @(negedge clk);

    model.tm = 32'h12345678; push(P_CFG);
    send5(8'hC0, 32'h12345678);
    model.rc = 16'h1000; model.dc = 16'h0020; push(P_CFG);
    send5(8'h81, 32'h00201000);

    push(P_ID);
    send_byte(8'h02, 500);

    model.fl = 8'h00; push(P_CFG);
    send5(8'h82, 32'h00000100);
    model.fl = 8'h05; push(P_CFG);
    send5(8'h82, 32'h00000005);

    model.dv = 24'hABCDEF; push(P_CFG);
    send5(8'h80, 32'h99ABCDEF);

    // Timeout: abort after 64 silent cycles following the 0xAA strobe.
    push(P_ERR);
    send_byte(8'h80, 4);
    @(negedge clk);
    c = cyc;
    rx_data = 8'hAA;
    rx_data_rdy = 1'b1;
    repeat (4) @(negedge clk);
    rx_data_rdy = 1'b0;
    while (cyc < c + 80) @(negedge clk);
    check("timeout_cycle", last_err_cyc, c + 67);
    push(P_ARM);
    send_byte(8'h01, 4);

    push(P_ERR);
    send_byte(8'h55, 4);
    model.tv = 32'hDEADBEEF; push(P_CFG);
    send5(8'hC1, 32'hDEADBEEF);
    send_byte(8'h11, 4);
    send_byte(8'h13, 4);
    model = '0; push(P_SWR);
    send_byte(8'h00, 4);
    check("clear_trig_value", trig_value, 32'h0);

    model.fl = 8'h3C; push(P_CFG);
    send5(8'h82, 32'h0000003C);
    send_byte(8'hC1, 4);
    send_byte(8'h11, 4);
    send_byte(8'h22, 4);
    do_reset();
    model = '0;
    check("midreset_flags", {24'h0, flags}, 32'h0);
    model.tv = 32'hCAFEF00D; push(P_CFG);
    send5(8'hC1, 32'hCAFEF00D);

    repeat (100) @(negedge clk);
    check("events_outstanding", exp_q.size(), 32'h0);
    check("final_trig_value", trig_value, 32'hCAFEF00D);
    check("final_trig_mask", trig_mask, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_controller.md
Name: uart_cmd_controller

Overview:
- Command sequencer between the UART receive path and the logic-analyzer capture core.
- Detects each byte delivered by the UART receiver and parses it as a SUMP-style command: 1-byte short commands, or a 1-byte opcode followed by 4 little-endian data bytes.
- Drives the capture core's configuration registers and control pulses.
- Aborts stalled multi-byte commands on an inter-byte timeout.

Parameters:
- TIMEOUT_CYCLES, 1_000_000: max input_clk cycles between bytes of a long command before abort.
- DIV_W, 24: width of the sample-clock divider register.

Ports:
- input_clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  byte from UART receiver; valid while rx_data_rdy is high
- rx_data_rdy  in  1  level from UART receiver, asynchronous to input_clk
- trig_mask  out  32  trigger mask register
- trig_value  out  32  trigger value register
- divider  out  DIV_W  sample divider register
- read_count  out  16  samples to read back
- delay_count  out  16  post-trigger delay
- flags  out  8  capture flags register
- arm_pulse  out  1  one-cycle start-capture strobe
- sw_reset_pulse  out  1  one-cycle capture-core reset strobe
- id_req_pulse  out  1  one-cycle request to transmit the ID string
- cfg_update  out  1  one-cycle strobe, any config register written
- cmd_error  out  1  one-cycle strobe, unknown opcode or timeout abort

Behaviour:
- Reset values:
  - All registers 0; all pulses 0.
  - FSM in IDLE; synchroniser flops 0.
  - On reset, the timeout counter, byte index and shift register clear.
- Byte strobe:
  - rx_data_rdy passes through a 2-flop synchroniser, then rising-edge detection.
  - byte_stb is high for one cycle per rx_data_rdy assertion.
  - rx_data is captured on the byte_stb cycle.
  - A level held for many cycles yields exactly one strobe.
- FSM states: IDLE, COLLECT.
- IDLE, on byte_stb, decodes the opcode:
  - 0x00 -> sw_reset_pulse, and all config registers cleared to 0.
  - 0x01 -> arm_pulse.
  - 0x02 -> id_req_pulse.
  - 0x11 or 0x13 -> accepted, no action.
  - 0xC0, 0xC1, 0x80, 0x81, 0x82 -> latch opcode, byte index = 0, go to COLLECT.
  - Any other byte -> cmd_error, stay in IDLE.
  - Short-command outputs (including the 0x00 register clear) are registered: they appear the cycle after byte_stb, high for exactly 1 cycle.
- COLLECT, on byte_stb:
  - Shift the byte into a 32-bit register, little-endian: byte k goes to bits [8k+7:8k].
  - Increment the byte index and reset the timeout counter.
  - After the 4th data byte, in the cycle after that byte_stb:
    - Commit the value and pulse cfg_update.
    - 0xC0 -> trig_mask.
    - 0xC1 -> trig_value.
    - 0x80 -> divider = data[DIV_W-1:0].
    - 0x81 -> read_count = data[15:0], delay_count = data[31:16].
    - 0x82 -> flags = data[7:0].
    - Return to IDLE.
- Data bytes are never decoded as opcodes; 0x00 or 0x01 received in COLLECT is data.
- Timeout:
  - In COLLECT, the counter increments each cycle without byte_stb.
  - When it reaches TIMEOUT_CYCLES-1: pulse cmd_error, discard partial data, return to IDLE.
  - No register changes on timeout.
  - If byte_stb and the terminal count coincide, byte_stb wins and no timeout occurs.
- Counter width: $clog2(TIMEOUT_CYCLES).
- Registers hold their value until rewritten, a 0x00 command, or reset.
- reset asserted mid-COLLECT: FSM to IDLE, all outputs to reset values next edge, partial command lost.

Test Plan:
- Reset check: assert reset 2 cycles -> all outputs 0, IDLE; then byte 0x01 -> arm_pulse high exactly 1 cycle, 1 cycle after byte_stb.
- Long command: send 0xC0,0x78,0x56,0x34,0x12 -> trig_mask=0x12345678 with single cfg_update pulse; send 0x81,0x00,0x10,0x20,0x00 -> read_count=0x1000, delay_count=0x0020.
- Stretched strobe: rx_data_rdy held high 500 cycles with 0x02 -> exactly one id_req_pulse.
- Data byte not decoded: 0x82,0x00,0x01,0x00,0x00 -> flags=0x00, no sw_reset_pulse or arm_pulse; 0x82,0x05,0,0,0 -> flags=0x05.
- Timeout (TIMEOUT_CYCLES=64): 0x80,0xAA then silence -> cmd_error after 64 idle cycles, divider unchanged; following 0x01 -> arm_pulse.
- Error and clear: byte 0x55 -> cmd_error, registers unchanged; byte 0x00 after loading trig_value=0xDEADBEEF -> sw_reset_pulse and trig_value=0.
- Mid-command reset: reset during COLLECT after 2 data bytes -> IDLE, no cfg_update; a full 0xC1 command afterwards loads correctly.
